// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the two-master Wishbone video arbiter.
//   arb_state_t        - arbiter FSM states (idle / video granted / CPU granted)
//   GNT_VIDEO, GNT_CPU - bit positions of each master in request vectors
//   DW, SW             - Wishbone data width and byte-select width
package wb_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_VIDEO = 2'd1,
        S_CPU   = 2'd2
    } arb_state_t;

    localparam bit GNT_VIDEO = 1'b0;
    localparam bit GNT_CPU   = 1'b1;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

endpackage : wb_arb_pkg

// File: rtl/wb_arb_starve_ctr.sv
// wb_arb_starve_ctr: saturating wait counter used to guarantee CPU progress.
// Ports:
//   clk_i  - system clock, rising edge
//   rst_i  - asynchronous active-low reset, clears the count
//   inc    - count one waiting cycle (saturates at MAX)
//   clr    - clear to zero; wins over inc
//   cnt    - current count
//   hit    - count has reached MAX
module wb_arb_starve_ctr #(
    parameter int unsigned MAX = 8,
    parameter int unsigned W   = $clog2(MAX + 1)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         hit
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (cnt >= MAX_V);

endmodule : wb_arb_starve_ctr

// File: rtl/wb_video_arbiter.sv
// wb_video_arbiter: two-master Wishbone classic arbiter. The VGA scanout master
// has priority over the CPU master; a starvation counter forces a CPU grant once
// the CPU has waited STARVE_MAX cycles. The grant is registered and held for the
// full duration of the winner's cyc; at least one idle cycle separates grants.
// Ports:
//   clk_i, rst_i            - clock (rising edge), asynchronous active-low reset
//   video_*                 - scanout master (cyc/stb/we/adr/sel/dat_m in, dat_s/ack out)
//   cpu_*                   - CPU master (same signal set)
//   mem_*                   - shared slave (cyc/stb/we/adr/sel/dat_m out, dat_s/ack in)
//   video_grants, cpu_grants, starve_hits - grant statistics, present only when
//                             WB_ARB_STATS_EN is defined
module wb_video_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned AW         = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
`ifdef WB_ARB_STATS_EN
    output logic [31:0]   video_grants,
    output logic [31:0]   cpu_grants,
    output logic [31:0]   starve_hits,
`endif
    input  logic          video_cyc,
    input  logic          video_stb,
    input  logic          video_we,
    input  logic [AW-1:0] video_adr,
    input  logic [SW-1:0] video_sel,
    input  logic [DW-1:0] video_dat_m,
    output logic [DW-1:0] video_dat_s,
    output logic          video_ack,
    input  logic          cpu_cyc,
    input  logic          cpu_stb,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [SW-1:0] cpu_sel,
    input  logic [DW-1:0] cpu_dat_m,
    output logic [DW-1:0] cpu_dat_s,
    output logic          cpu_ack,
    output logic          mem_cyc,
    output logic          mem_stb,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [SW-1:0] mem_sel,
    output logic [DW-1:0] mem_dat_m,
    input  logic [DW-1:0] mem_dat_s,
    input  logic          mem_ack
);

    localparam int unsigned SCW = $clog2(STARVE_MAX + 1);

    arb_state_t     state, state_nxt;
    logic [1:0]     req;
    logic [SCW-1:0] starve_cnt;
    logic           starve_hit;
    logic           starve_inc;
    logic           starve_clr;
    logic           forced;

    assign req[GNT_VIDEO] = video_cyc & video_stb;
    assign req[GNT_CPU]   = cpu_cyc & cpu_stb;

    // Read data is broadcast; only the ack qualifies it for the granted master.
    assign video_dat_s = mem_dat_s;
    assign cpu_dat_s   = mem_dat_s;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        forced    = 1'b0;
        mem_cyc   = 1'b0;
        mem_stb   = 1'b0;
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_sel   = '0;
        mem_dat_m = '0;
        video_ack = 1'b0;
        cpu_ack   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req[GNT_VIDEO] && req[GNT_CPU]) begin
                    if (starve_hit) begin
                        state_nxt = S_CPU;
                        forced    = 1'b1;
                    end else begin
                        state_nxt = S_VIDEO;
                    end
                end else if (req[GNT_VIDEO]) begin
                    state_nxt = S_VIDEO;
                end else if (req[GNT_CPU]) begin
                    state_nxt = S_CPU;
                end
            end
            S_VIDEO: begin
                mem_cyc   = video_cyc;
                mem_stb   = video_stb;
                mem_we    = video_we;
                mem_adr   = video_adr;
                mem_sel   = video_sel;
                mem_dat_m = video_dat_m;
                video_ack = mem_ack & video_cyc;
                if (!video_cyc) begin
                    state_nxt = S_IDLE;
                end
            end
            S_CPU: begin
                mem_cyc   = cpu_cyc;
                mem_stb   = cpu_stb;
                mem_we    = cpu_we;
                mem_adr   = cpu_adr;
                mem_sel   = cpu_sel;
                mem_dat_m = cpu_dat_m;
                cpu_ack   = mem_ack & cpu_cyc;
                if (!cpu_cyc) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // CPU waiting = cpu_cyc held while someone else (or nobody) owns the bus.
    assign starve_inc = cpu_cyc && (state != S_CPU);
    assign starve_clr = (state != S_CPU) && (state_nxt == S_CPU);

    wb_arb_starve_ctr #(
        .MAX (STARVE_MAX),
        .W   (SCW)
    ) u_starve (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .cnt   (starve_cnt),
        .hit   (starve_hit)
    );

`ifdef WB_ARB_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            video_grants <= '0;
            cpu_grants   <= '0;
            starve_hits  <= '0;
        end else if (state == S_IDLE) begin
            if (state_nxt == S_VIDEO) begin
                video_grants <= video_grants + 32'd1;
            end
            if (state_nxt == S_CPU) begin
                cpu_grants <= cpu_grants + 32'd1;
            end
            if (forced) begin
                starve_hits <= starve_hits + 32'd1;
            end
        end
    end
`endif

endmodule : wb_video_arbiter

// File: tb/tb_wb_video_arbiter.sv
// tb_wb_video_arbiter: self-checking bench for wb_video_arbiter (STARVE_MAX=8).
// Directed scenario tasks plus a randomized run against a bus-ownership model.
// Stats checks are included when WB_ARB_STATS_EN is defined.
module tb_wb_video_arbiter;

    localparam int unsigned SMAX = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        v_cyc = 1'b0, v_stb = 1'b0, v_we = 1'b0;
    logic [31:0] v_adr = '0, v_dat = '0;
    logic [3:0]  v_sel = '0;
    logic        c_cyc = 1'b0, c_stb = 1'b0, c_we = 1'b0;
    logic [31:0] c_adr = '0, c_dat = '0;
    logic [3:0]  c_sel = '0;
    logic        m_ack = 1'b0;
    logic [31:0] m_dat = '0;

    logic [31:0] video_dat_s, cpu_dat_s, mem_adr, mem_dat_m;
    logic        video_ack, cpu_ack, mem_cyc, mem_stb, mem_we;
    logic [3:0]  mem_sel;
`ifdef WB_ARB_STATS_EN
    logic [31:0] video_grants, cpu_grants, starve_hits;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    wb_video_arbiter #(
        .STARVE_MAX (SMAX),
        .AW         (32)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
`ifdef WB_ARB_STATS_EN
        .video_grants (video_grants),
        .cpu_grants   (cpu_grants),
        .starve_hits  (starve_hits),
`endif
        .video_cyc    (v_cyc),
        .video_stb    (v_stb),
        .video_we     (v_we),
        .video_adr    (v_adr),
        .video_sel    (v_sel),
        .video_dat_m  (v_dat),
        .video_dat_s  (video_dat_s),
        .video_ack    (video_ack),
        .cpu_cyc      (c_cyc),
        .cpu_stb      (c_stb),
        .cpu_we       (c_we),
        .cpu_adr      (c_adr),
        .cpu_sel      (c_sel),
        .cpu_dat_m    (c_dat),
        .cpu_dat_s    (cpu_dat_s),
        .cpu_ack      (cpu_ack),
        .mem_cyc      (mem_cyc),
        .mem_stb      (mem_stb),
        .mem_we       (mem_we),
        .mem_adr      (mem_adr),
        .mem_sel      (mem_sel),
        .mem_dat_m    (mem_dat_m),
        .mem_dat_s    (m_dat),
        .mem_ack      (m_ack)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    task automatic idle_inputs();
        v_cyc = 1'b0; v_stb = 1'b0; v_we = 1'b0; v_adr = '0; v_sel = '0; v_dat = '0;
        c_cyc = 1'b0; c_stb = 1'b0; c_we = 1'b0; c_adr = '0; c_sel = '0; c_dat = '0;
        m_ack = 1'b0; m_dat = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        #1;
        checks++;
        if (mem_cyc !== 1'b0 || mem_adr !== 32'h0 || video_ack !== 1'b0 || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: cyc=%0b adr=%0h vack=%0b cack=%0b required all 0", mem_cyc, mem_adr, video_ack, cpu_ack);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        v_cyc = 1'b1; v_stb = 1'b1; v_adr = 32'h40;
        @(negedge clk_i);
        #1;
        checks++;
        if (mem_cyc !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_grant: mem_cyc=%0b required 1", mem_cyc);
        end
        #1;
        m_ack = 1'b1; c_cyc = 1'b1;
        rst_i = 1'b0;
        #1;
        checks++;
        if (mem_cyc !== 1'b0 || mem_adr !== 32'h0 || video_ack !== 1'b0 || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_midcycle: cyc=%0b adr=%0h vack=%0b cack=%0b required all 0", mem_cyc, mem_adr, video_ack, cpu_ack);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (mem_cyc !== 1'b0 || video_ack !== 1'b0 || int'(dut.starve_cnt) != 0) begin
            errors++;
            $display("FAIL reset_during: cyc=%0b vack=%0b starve=%0d required 0/0/0", mem_cyc, video_ack, dut.starve_cnt);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        idle_inputs();
        rst_i = 1'b1;
        #1;
        checks++;
        if (mem_cyc !== 1'b0 || int'(dut.starve_cnt) != 0) begin
            errors++;
            $display("FAIL reset_release: cyc=%0b starve=%0d required 0/0", mem_cyc, dut.starve_cnt);
        end
    endtask

    task automatic test_video_read();
        do_reset();
        @(negedge clk_i);
        v_cyc = 1'b1; v_stb = 1'b1; v_we = 1'b0; v_adr = 32'h100; v_sel = 4'hF;
        #1;
        checks++;
        if (mem_cyc !== 1'b0) begin
            errors++;
            $display("FAIL vread_latency: mem_cyc=%0b required 0 in request cycle", mem_cyc);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i);
            #1;
            checks++;
            if (mem_cyc !== 1'b1 || mem_adr !== 32'h100 || mem_we !== 1'b0 || video_ack !== 1'b0 || cpu_ack !== 1'b0) begin
                errors++;
                $display("FAIL vread_wait%0d: cyc=%0b adr=%0h we=%0b vack=%0b cack=%0b required 1/100/0/0/0",
                         k, mem_cyc, mem_adr, mem_we, video_ack, cpu_ack);
            end
        end
        @(negedge clk_i);
        m_ack = 1'b1; m_dat = 32'hDEADBEEF;
        #1;
        checks++;
        if (video_ack !== 1'b1 || video_dat_s !== 32'hDEADBEEF || cpu_ack !== 1'b0 || cpu_dat_s !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL vread_ack: vack=%0b vdat=%0h cack=%0b cdat=%0h required 1/deadbeef/0/deadbeef",
                     video_ack, video_dat_s, cpu_ack, cpu_dat_s);
        end
        @(negedge clk_i);
        v_cyc = 1'b0; v_stb = 1'b0; m_ack = 1'b0;
        #1;
        checks++;
        if (mem_cyc !== 1'b0) begin
            errors++;
            $display("FAIL vread_drop: mem_cyc=%0b required 0", mem_cyc);
        end
    endtask

    task automatic test_both_request();
        do_reset();
        @(negedge clk_i);
        v_cyc = 1'b1; v_stb = 1'b1; v_adr = 32'hA00;
        c_cyc = 1'b1; c_stb = 1'b1; c_adr = 32'hC00;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i);
            #1;
            checks++;
            if (mem_cyc !== 1'b1 || mem_adr !== 32'hA00 || int'(dut.starve_cnt) != k) begin
                errors++;
                $display("FAIL both_video%0d: cyc=%0b adr=%0h starve=%0d required 1/a00/%0d", k, mem_cyc, mem_adr, dut.starve_cnt, k);
            end
        end
        @(negedge clk_i);
        v_cyc = 1'b0; v_stb = 1'b0;
        #1;
        checks++;
        if (mem_cyc !== 1'b0 || int'(dut.starve_cnt) != 4) begin
            errors++;
            $display("FAIL both_drop: cyc=%0b starve=%0d required 0/4", mem_cyc, dut.starve_cnt);
        end
        @(negedge clk_i);
        #1;
        checks++;
        if (mem_cyc !== 1'b0 || int'(dut.starve_cnt) != 5) begin
            errors++;
            $display("FAIL both_turnaround: cyc=%0b starve=%0d required 0/5", mem_cyc, dut.starve_cnt);
        end
        @(negedge clk_i);
        #1;
        checks++;
        if (mem_cyc !== 1'b1 || mem_adr !== 32'hC00 || int'(dut.starve_cnt) != 0) begin
            errors++;
            $display("FAIL both_cpu_grant: cyc=%0b adr=%0h starve=%0d required 1/c00/0", mem_cyc, mem_adr, dut.starve_cnt);
        end
        @(negedge clk_i);
        idle_inputs();
    endtask

    task automatic test_starvation();
        do_reset();
        @(negedge clk_i);
        m_ack = 1'b1;
        c_cyc = 1'b1; c_stb = 1'b1; c_adr = 32'hC40;
        v_cyc = 1'b1; v_stb = 1'b1; v_adr = 32'hA40;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_i);
            v_cyc = ((k % 2) == 0); v_stb = v_cyc;
            #1;
            checks++;
            if (mem_cyc !== 1'b0 || cpu_ack !== 1'b0 || video_ack !== 1'b0 || int'(dut.starve_cnt) != k) begin
                errors++;
                $display("FAIL starve_wait%0d: cyc=%0b cack=%0b vack=%0b starve=%0d required 0/0/0/%0d",
                         k, mem_cyc, cpu_ack, video_ack, dut.starve_cnt, k);
            end
        end
        @(negedge clk_i);
        v_cyc = 1'b0; v_stb = 1'b0;
        #1;
        checks++;
        if (mem_cyc !== 1'b1 || mem_adr !== 32'hC40 || cpu_ack !== 1'b1 || video_ack !== 1'b0 || int'(dut.starve_cnt) != 0) begin
            errors++;
            $display("FAIL starve_cpu_win: cyc=%0b adr=%0h cack=%0b vack=%0b starve=%0d required 1/c40/1/0/0",
                     mem_cyc, mem_adr, cpu_ack, video_ack, dut.starve_cnt);
        end
        @(negedge clk_i);
        idle_inputs();
    endtask

    task automatic test_cpu_write();
        do_reset();
        @(negedge clk_i);
        c_cyc = 1'b1; c_stb = 1'b1; c_we = 1'b1; c_sel = 4'b0011; c_dat = 32'h1234; c_adr = 32'h200;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_i);
            v_cyc = 1'b1; v_stb = 1'b1; v_we = 1'b0; v_adr = 32'h300; v_sel = 4'hF; v_dat = 32'h5555;
            m_ack = (k == 3);
            #1;
            checks++;
            if (mem_cyc !== 1'b1 || mem_we !== 1'b1 || mem_sel !== 4'b0011 || mem_dat_m !== 32'h1234 ||
                mem_adr !== 32'h200 || cpu_ack !== (k == 3) || video_ack !== 1'b0) begin
                errors++;
                $display("FAIL cwrite_hold%0d: cyc=%0b we=%0b sel=%0h dat=%0h adr=%0h cack=%0b vack=%0b required 1/1/3/1234/200/%0b/0",
                         k, mem_cyc, mem_we, mem_sel, mem_dat_m, mem_adr, cpu_ack, video_ack, (k == 3));
            end
        end
        @(negedge clk_i);
        c_cyc = 1'b0; c_stb = 1'b0; m_ack = 1'b0;
        #1;
        checks++;
        if (mem_cyc !== 1'b0) begin
            errors++;
            $display("FAIL cwrite_drop: mem_cyc=%0b required 0", mem_cyc);
        end
        @(negedge clk_i);
        #1;
        checks++;
        if (mem_cyc !== 1'b0) begin
            errors++;
            $display("FAIL cwrite_turnaround: mem_cyc=%0b required 0", mem_cyc);
        end
        @(negedge clk_i);
        #1;
        checks++;
        if (mem_cyc !== 1'b1 || mem_adr !== 32'h300 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL cwrite_video_next: cyc=%0b adr=%0h we=%0b required 1/300/0", mem_cyc, mem_adr, mem_we);
        end
        @(negedge clk_i);
        idle_inputs();
    endtask

    // Reference: owner of the bus (0 none, 1 video, 2 cpu) and how long the CPU
    // has been kept waiting, updated from the arbitration rules once per cycle.
    task automatic test_random();
        int          owner = 0;
        int          cpu_wait = 0;
        int          nxt;
        bit          vr, cr;
        logic        e_cyc, e_stb, e_we, e_vack, e_cack;
        logic [31:0] e_adr, e_dat;
        logic [3:0]  e_sel;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk_i);
            v_cyc = v_cyc ? ($urandom_range(99, 0) < 75) : ($urandom_range(99, 0) < 30);
            v_stb = v_cyc & ($urandom_range(99, 0) < 85);
            c_cyc = c_cyc ? ($urandom_range(99, 0) < 70) : ($urandom_range(99, 0) < 35);
            c_stb = c_cyc & ($urandom_range(99, 0) < 85);
            v_we = 1'($urandom_range(1, 0)); c_we = 1'($urandom_range(1, 0));
            v_adr = $urandom(); c_adr = $urandom(); v_dat = $urandom(); c_dat = $urandom();
            v_sel = 4'($urandom_range(15, 0)); c_sel = 4'($urandom_range(15, 0));
            m_ack = ($urandom_range(99, 0) < 40); m_dat = $urandom();
            e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_sel = '0; e_dat = '0;
            e_vack = 1'b0; e_cack = 1'b0;
            if (owner == 1) begin
                e_cyc = v_cyc; e_stb = v_stb; e_we = v_we; e_adr = v_adr; e_sel = v_sel; e_dat = v_dat;
                e_vack = m_ack & v_cyc;
            end else if (owner == 2) begin
                e_cyc = c_cyc; e_stb = c_stb; e_we = c_we; e_adr = c_adr; e_sel = c_sel; e_dat = c_dat;
                e_cack = m_ack & c_cyc;
            end
            #1;
            checks++;
            if (mem_cyc !== e_cyc || mem_stb !== e_stb || mem_we !== e_we || mem_adr !== e_adr ||
                mem_sel !== e_sel || mem_dat_m !== e_dat) begin
                errors++;
                $display("FAIL rand_mem%0d: cyc/stb/we=%0b%0b%0b adr=%0h sel=%0h dat=%0h required %0b%0b%0b/%0h/%0h/%0h",
                         n, mem_cyc, mem_stb, mem_we, mem_adr, mem_sel, mem_dat_m, e_cyc, e_stb, e_we, e_adr, e_sel, e_dat);
            end
            checks++;
            if (video_ack !== e_vack || cpu_ack !== e_cack || video_dat_s !== m_dat || cpu_dat_s !== m_dat) begin
                errors++;
                $display("FAIL rand_ack%0d: vack=%0b cack=%0b vdat=%0h cdat=%0h required %0b/%0b/%0h/%0h",
                         n, video_ack, cpu_ack, video_dat_s, cpu_dat_s, e_vack, e_cack, m_dat, m_dat);
            end
            checks++;
            if (int'(dut.starve_cnt) != cpu_wait) begin
                errors++;
                $display("FAIL rand_starve%0d: starve=%0d required %0d", n, dut.starve_cnt, cpu_wait);
            end
            vr = v_cyc & v_stb;
            cr = c_cyc & c_stb;
            nxt = owner;
            if (owner == 0) begin
                if (vr && cr) nxt = (cpu_wait >= int'(SMAX)) ? 2 : 1;
                else if (vr)  nxt = 1;
                else if (cr)  nxt = 2;
            end else if (owner == 1 && !v_cyc) begin
                nxt = 0;
            end else if (owner == 2 && !c_cyc) begin
                nxt = 0;
            end
            if (owner != 2 && nxt == 2) cpu_wait = 0;
            else if (c_cyc && owner != 2 && cpu_wait < int'(SMAX)) cpu_wait = cpu_wait + 1;
            @(posedge clk_i);
            owner = nxt;
        end
        @(negedge clk_i);
        idle_inputs();
    endtask

`ifdef WB_ARB_STATS_EN
    task automatic run_txn(input bit is_cpu);
        @(negedge clk_i);
        if (is_cpu) begin c_cyc = 1'b1; c_stb = 1'b1; end
        else        begin v_cyc = 1'b1; v_stb = 1'b1; end
        @(negedge clk_i);
        @(negedge clk_i);
        idle_inputs();
        @(negedge clk_i);
    endtask

    task automatic test_stats();
        do_reset();
        @(negedge clk_i);
        c_cyc = 1'b1; c_stb = 1'b1;
        v_cyc = 1'b1; v_stb = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_i);
            v_cyc = ((k % 2) == 0); v_stb = v_cyc;
        end
        @(negedge clk_i);
        v_cyc = 1'b0; v_stb = 1'b0;
        @(negedge clk_i);
        idle_inputs();
        run_txn(1'b0);
        run_txn(1'b1);
        run_txn(1'b1);
        #1;
        checks++;
        if (video_grants !== 32'd5 || cpu_grants !== 32'd3 || starve_hits !== 32'd1) begin
            errors++;
            $display("FAIL stats: video=%0d cpu=%0d starve=%0d required 5/3/1", video_grants, cpu_grants, starve_hits);
        end
    endtask
`endif

    initial begin
        idle_inputs();
        rst_i = 1'b0;
        test_reset();
        test_video_read();
        test_both_request();
        test_starvation();
        test_cpu_write();
        test_random();
`ifdef WB_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_wb_video_arbiter

// File: doc/wb_video_arbiter.md
Name: wb_video_arbiter

Overview:
- Two-master Wishbone (classic) arbiter sharing one memory slave between the VGA scanout master (line-buffer fill, one word per cycle-envelope) and a CPU master.
- Scanout has priority; a starvation counter guarantees CPU forward progress.
- Sits between the gm_13h-class scanout engine, the CPU bus port and the SDRAM/SRAM controller.
- Grant is registered and locked for the full duration of the winner's cyc.

Parameters:
- STARVE_MAX, 8: CPU-wait cycles after which CPU beats a pending video request at the next arbitration.
- AW, 32: address width carried through.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- video  if_wb.slave  -  scanout master port (priority requester).
- cpu    if_wb.slave  -  CPU master port.
- mem    if_wb.master -  shared downstream slave.
- Data direction names follow the if_wb convention, including the NO_MODPORT_EXPRESSIONS dat_s/dat_m variant.

Behaviour:
- States: S_IDLE, S_VIDEO, S_CPU (registered).
- Request: the master's cyc & stb.
- Reset (rst_i low, any time including mid-transfer):
  - state=S_IDLE, starve_cnt=0.
  - mem.cyc=mem.stb=mem.we=0, mem.adr=0, mem.sel=0, mem.dat_o=0.
  - video.ack=cpu.ack=0.
  - An in-flight slave ack is dropped; masters must restart.
- S_IDLE:
  - mem outputs all zero.
  - Video request only -> S_VIDEO.
  - CPU request only -> S_CPU.
  - Both requesting: S_CPU if starve_cnt >= STARVE_MAX, else S_VIDEO.
  - Neither requesting: stay in S_IDLE.
- S_VIDEO / S_CPU:
  - mem.cyc/stb/we/adr/sel/dat_o driven combinationally from the granted master.
  - mem.ack routed only to the granted master; the other master's ack=0.
  - mem.dat_i broadcast to both masters' read data.
  - The granted master dropping cyc -> S_IDLE next cycle; mem.cyc follows to 0 in that same cycle.
  - No pre-emption while cyc is held.
- Latency:
  - Request at edge n -> grant state at n+1 -> mem.cyc/stb visible during cycle n+1.
  - Minimum one S_IDLE cycle between consecutive grants (bus turnaround).
- starve_cnt, width $clog2(STARVE_MAX+1):
  - Increments each cycle cpu.cyc=1 and state!=S_CPU.
  - Saturates at STARVE_MAX.
  - Clears to 0 on entry to S_CPU.
  - Holds when cpu.cyc=0.
- Simultaneous events:
  - Both masters assert in the same cycle -> arbitration rule above.
  - Granted master drops cyc the same cycle the other asserts -> S_IDLE first, other granted on the following edge.
- mem.ack while the granted master's cyc is low: ignored.
- mem.ack in S_IDLE: ignored.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- Defined:
  - Adds outputs video_grants[31:0], cpu_grants[31:0] and starve_hits[31:0].
  - Each counter increments on the S_IDLE->grant edge; starve_hits increments on grants forced by starve_cnt.
  - Counters wrap modulo 2^32.
  - Counters reset to 0 by rst_i.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Package wb_arb_pkg:
  - arb_state_t enum (S_IDLE, S_VIDEO, S_CPU).
  - Grant-index constants GNT_VIDEO=0, GNT_CPU=1.
- Sub-module wb_arb_starve_ctr: saturating counter with inc, clr and threshold-reached output.
- Muxing and FSM stay in the top level.

Test Plan:
- Reset while video is granted mid-cycle (mem.cyc=1), rst_i low 2 cycles -> mem.cyc=0 and both acks 0 immediately; state S_IDLE; starve_cnt=0 after release.
- Video-only read at adr 0x100, slave acks 3 cycles later with 0xDEADBEEF:
  - mem.cyc rises 1 cycle after video.cyc.
  - video.ack=1 with data 0xDEADBEEF.
  - cpu.ack stays 0 throughout.
- Both request in the same cycle, starve_cnt=0 -> video granted.
  - CPU must wait; starve_cnt counts 1..N while waiting.
  - CPU is granted after video drops cyc plus 1 idle cycle.
- Video re-requests every other cycle continuously while CPU waits, STARVE_MAX=8:
  - CPU wins the first arbitration after starve_cnt reaches 8.
  - starve_cnt reads 0 the cycle after the CPU grant.
- CPU write (we=1, sel=4'b0011, dat=0x1234) granted:
  - Video request mid-transfer does not pre-empt.
  - mem.we/sel/dat_o match the CPU values until cpu.cyc drops.
- With WB_ARB_STATS_EN: 5 video + 3 CPU transactions, one of which is starvation-forced -> video_grants=5, cpu_grants=3, starve_hits=1.
